// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Imported by if_stage and its fetch buffer.
package if_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } if_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP          = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO of fetched {pc, instr} entries with zero-cycle head read.
// Flush empties it; the caller never pushes when full or pops when empty.
module fetch_fifo
  import if_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output logic [AW:0]  count,
  output fetch_entry_t head,
  output logic         empty
);

  fetch_entry_t mem_q [DEPTH];
  fetch_entry_t mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding imem request, buffered
// responses, redirect flush with stale-response drain.
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic        instr_valid
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  if_state_e     state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   pending_pc_q, pending_pc_d;
  logic          granted;
  logic          push;
  logic          pop;
  logic          has_room;
  logic [CW-1:0] fifo_count;
  logic          fifo_empty;
  fetch_entry_t  fifo_head;
  fetch_entry_t  push_entry;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH;
      fetch_pc_q   <= word_align(RESET_PC);
      pending_pc_q <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    unique case (state_q)
      FETCH: begin
        if (redirect_en) state_d = granted ? DRAIN : FETCH;
        else if (granted) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) state_d = FETCH;
        else if (redirect_en) state_d = DRAIN;
      end
      DRAIN: begin
        if (imem_rvalid) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
    if (redirect_en) begin
      fetch_pc_d = word_align(redirect_pc);
    end else if (granted) begin
      fetch_pc_d   = fetch_pc_q + PC_STEP;
      pending_pc_d = fetch_pc_q;
    end
  end

  // Requesting only with a free slot guarantees every response lands.
  always_comb begin
    has_room    = (fifo_count < CW'(FIFO_DEPTH));
    imem_req    = !rst && (state_q == FETCH) && !redirect_en && has_room;
    imem_addr   = fetch_pc_q;
    granted     = imem_req && imem_gnt;
    push        = !rst && (state_q == WAIT) && imem_rvalid && !redirect_en;
    instr_valid = !rst && !fifo_empty;
    pop         = instr_valid && !stall && !redirect_en;
    instruction = instr_valid ? fifo_head.instr : NOP_INSTR;
    pc          = instr_valid ? fifo_head.pc : 32'h0;
    push_entry  = '{pc: pending_pc_q, instr: imem_rdata};
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .flush    (redirect_en),
    .count    (fifo_count),
    .head     (fifo_head),
    .empty    (fifo_empty)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: streaming, stall, redirects, reset, wrap.
// A second instance covers FIFO_DEPTH = 4 and a wrapping RESET_PC.
module tb_if_stage;
  import if_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b1;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        stall = 1'b0;
  logic [31:0] instruction;
  logic [31:0] pc;
  logic        instr_valid;

  logic        auto_mode = 1'b1;
  logic        man_rvalid = 1'b0;
  logic [31:0] man_rdata = 32'h0;
  logic        auto_rvalid;
  logic [31:0] auto_rdata;

  logic        rst2 = 1'b1;
  logic        imem_req2;
  logic [31:0] imem_addr2;
  logic        gnt2 = 1'b1;
  logic        rvalid2;
  logic [31:0] rdata2;
  logic        redir2 = 1'b0;
  logic [31:0] redir_pc2 = 32'h0;
  logic        stall2 = 1'b0;
  logic [31:0] instr2;
  logic [31:0] pc2;
  logic        valid2;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5C3_0013;
  endfunction

  assign imem_rvalid = auto_mode ? auto_rvalid : man_rvalid;
  assign imem_rdata  = auto_mode ? auto_rdata : man_rdata;

  always @(posedge clk) begin
    if (rst) auto_rvalid <= 1'b0;
    else auto_rvalid <= imem_req && imem_gnt;
    auto_rdata <= mem_word(imem_addr);
  end

  always @(posedge clk) begin
    if (rst2) rvalid2 <= 1'b0;
    else rvalid2 <= imem_req2 && gnt2;
    rdata2 <= mem_word(imem_addr2);
  end

  if_stage dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .stall(stall),
    .instruction(instruction), .pc(pc),
    .instr_valid(instr_valid)
  );

  if_stage #(
    .RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)
  ) dut2 (
    .clk(clk), .rst(rst2),
    .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_gnt(gnt2), .imem_rvalid(rvalid2),
    .imem_rdata(rdata2),
    .redirect_en(redir2), .redirect_pc(redir_pc2),
    .stall(stall2),
    .instruction(instr2), .pc(pc2),
    .instr_valid(valid2)
  );

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1; redirect_en = 1'b0; stall = 1'b0;
    imem_gnt = 1'b1; auto_mode = 1'b1; man_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; redirect_en = 1'b0;
    imem_gnt = 1'b1; auto_mode = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if (imem_req !== 1'b0) begin
      n_err++; $display("FAIL rst_req: got %b expected 0", imem_req);
    end
    n_vec++;
    if (instr_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_valid: got %b expected 0", instr_valid);
    end
    n_vec++;
    if (instruction !== 32'h0000_0013) begin
      n_err++; $display("FAIL rst_nop: got %h expected 00000013", instruction);
    end
    n_vec++;
    if (pc !== 32'h0) begin
      n_err++; $display("FAIL rst_pc: got %h expected 0", pc);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_err++;
      $display("FAIL first_req: got req=%b addr=%h expected 1/00000000",
               imem_req, imem_addr);
    end
  endtask

  task automatic test_stream;
    int got;
    int first;
    logic [31:0] exp_pc;
    do_reset();
    got = 0; first = -1;
    for (int i = 0; i < 40 && got < 4; i++) begin
      if (i > 0) @(negedge clk);
      if (instr_valid && !stall) begin
        if (first < 0) first = i;
        exp_pc = 32'(4 * got);
        n_vec++;
        if (pc !== exp_pc || instruction !== mem_word(exp_pc)) begin
          n_err++;
          $display("FAIL stream_%0d: got pc=%h ins=%h expected %h/%h",
                   got, pc, instruction, exp_pc, mem_word(exp_pc));
        end
        got++;
      end
    end
    n_vec++;
    if (got != 4 || first != 2) begin
      n_err++;
      $display("FAIL stream_lat: got n=%0d first=%0d expected 4/2",
               got, first);
    end
  endtask

  task automatic test_stall;
    int got;
    logic [31:0] exp_pc;
    do_reset();
    stall = 1'b1;
    repeat (6) @(negedge clk);
    n_vec++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b1 || pc !== 32'h0
        || instruction !== mem_word(32'h0)) begin
      n_err++;
      $display("FAIL stall_full: got req=%b v=%b pc=%h expected 0/1/0",
               imem_req, instr_valid, pc);
    end
    stall = 1'b0;
    #1;
    got = 0;
    for (int i = 0; i < 40 && got < 4; i++) begin
      if (i > 0) @(negedge clk);
      if (instr_valid && !stall) begin
        exp_pc = 32'(4 * got);
        n_vec++;
        if (pc !== exp_pc) begin
          n_err++;
          $display("FAIL stall_seq_%0d: got %h expected %h",
                   got, pc, exp_pc);
        end
        got++;
      end
    end
    n_vec++;
    if (got != 4) begin
      n_err++; $display("FAIL stall_count: got %0d expected 4", got);
    end
  endtask

  task automatic test_redirect_wait;
    do_reset();
    auto_mode = 1'b0;
    @(negedge clk);
    n_vec++;
    if (imem_req !== 1'b0) begin
      n_err++; $display("FAIL rw_wait_req: got %b expected 0", imem_req);
    end
    redirect_en = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    redirect_en = 1'b0;
    #1;
    n_vec++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rw_drain: got req=%b v=%b expected 0/0",
               imem_req, instr_valid);
    end
    @(negedge clk);
    @(negedge clk);
    man_rvalid = 1'b1; man_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    man_rvalid = 1'b0;
    #1;
    n_vec++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1
        || imem_addr !== 32'h100) begin
      n_err++;
      $display("FAIL rw_refetch: got v=%b req=%b addr=%h expected 0/1/100",
               instr_valid, imem_req, imem_addr);
    end
    @(negedge clk);
    man_rvalid = 1'b1; man_rdata = mem_word(32'h100);
    @(negedge clk);
    man_rvalid = 1'b0; imem_gnt = 1'b0;
    #1;
    n_vec++;
    if (instr_valid !== 1'b1 || pc !== 32'h100
        || instruction !== mem_word(32'h100)) begin
      n_err++;
      $display("FAIL rw_first: got v=%b pc=%h ins=%h expected 1/100/%h",
               instr_valid, pc, instruction, mem_word(32'h100));
    end
  endtask

  task automatic test_redirect_rvalid;
    do_reset();
    auto_mode = 1'b0;
    @(negedge clk);
    man_rvalid = 1'b1; man_rdata = 32'hBAD0_0001;
    redirect_en = 1'b1; redirect_pc = 32'h203;
    @(negedge clk);
    man_rvalid = 1'b0; redirect_en = 1'b0; imem_gnt = 1'b0;
    #1;
    n_vec++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1
        || imem_addr !== 32'h200) begin
      n_err++;
      $display("FAIL rr_drop: got v=%b req=%b addr=%h expected 0/1/200",
               instr_valid, imem_req, imem_addr);
    end
    @(negedge clk);
    man_rvalid = 1'b1; man_rdata = 32'hBAD0_0002;
    @(negedge clk);
    man_rvalid = 1'b0;
    #1;
    n_vec++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1
        || imem_addr !== 32'h200) begin
      n_err++;
      $display("FAIL rr_stray: got v=%b req=%b addr=%h expected 0/1/200",
               instr_valid, imem_req, imem_addr);
    end
  endtask

  task automatic test_reset_mid_wait;
    do_reset();
    repeat (3) @(negedge clk);
    n_vec++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h8) begin
      n_err++;
      $display("FAIL rmw_wait: got req=%b addr=%h expected 0/8",
               imem_req, imem_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_vec++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rmw_inrst: got req=%b v=%b expected 0/0",
               imem_req, instr_valid);
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1
        || imem_addr !== 32'h0) begin
      n_err++;
      $display("FAIL rmw_post: got v=%b req=%b addr=%h expected 0/1/0",
               instr_valid, imem_req, imem_addr);
    end
    @(negedge clk);
    n_vec++;
    if (instr_valid !== 1'b0) begin
      n_err++; $display("FAIL rmw_stale: got %b expected 0", instr_valid);
    end
  endtask

  task automatic test_wrap_depth4;
    int got;
    logic [31:0] exp_pc;
    @(negedge clk);
    rst2 = 1'b1; stall2 = 1'b0;
    repeat (2) @(negedge clk);
    rst2 = 1'b0; stall2 = 1'b1;
    #1;
    n_vec++;
    if (imem_req2 !== 1'b1 || imem_addr2 !== 32'hFFFF_FFF8) begin
      n_err++;
      $display("FAIL wrap_first: got req=%b addr=%h expected 1/fffffff8",
               imem_req2, imem_addr2);
    end
    repeat (12) @(negedge clk);
    n_vec++;
    if (imem_req2 !== 1'b0 || valid2 !== 1'b1
        || pc2 !== 32'hFFFF_FFF8) begin
      n_err++;
      $display("FAIL wrap_full: got req=%b v=%b pc=%h expected 0/1/fffffff8",
               imem_req2, valid2, pc2);
    end
    stall2 = 1'b0;
    #1;
    got = 0;
    exp_pc = 32'hFFFF_FFF8;
    for (int i = 0; i < 60 && got < 6; i++) begin
      if (i > 0) @(negedge clk);
      if (valid2 && !stall2) begin
        n_vec++;
        if (pc2 !== exp_pc || instr2 !== mem_word(exp_pc)) begin
          n_err++;
          $display("FAIL wrap_seq_%0d: got pc=%h ins=%h expected %h/%h",
                   got, pc2, instr2, exp_pc, mem_word(exp_pc));
        end
        exp_pc = exp_pc + 32'd4;
        got++;
      end
    end
    n_vec++;
    if (got != 6) begin
      n_err++; $display("FAIL wrap_count: got %0d expected 6", got);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_rvalid();
    test_reset_mid_wait();
    test_wrap_depth4();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, the fetched-instruction buffer depth; legal values are 2 or 4.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, rising-edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port imem_req, output, 1 bit: fetch request to instruction memory.
REQ-006 SHALL have port imem_addr, output, 32 bits: fetch address, word aligned.
REQ-007 SHALL have port imem_gnt, input, 1 bit: memory accepts the request this cycle.
REQ-008 SHALL have port imem_rvalid, input, 1 bit: read data valid.
REQ-009 SHALL have port imem_rdata, input, 32 bits: fetched instruction word.
REQ-010 SHALL have port redirect_en, input, 1 bit: flush/branch-taken from EX.
REQ-011 SHALL have port redirect_pc, input, 32 bits: target PC, i.e. the ID stage nextpc.
REQ-012 SHALL have port stall, input, 1 bit: ID cannot accept an instruction this cycle.
REQ-013 SHALL have port instruction, output, 32 bits: instruction to ID.
REQ-014 SHALL have port pc, output, 32 bits: PC of that instruction.
REQ-015 SHALL have port instr_valid, output, 1 bit: instruction/pc are meaningful.

Function
REQ-016 SHALL use a 3-state FSM: FETCH (may request), WAIT (one request granted, awaiting rvalid), DRAIN (discard one stale response).
REQ-017 SHALL allow at most one outstanding request.
REQ-018 SHALL assert imem_req only in FETCH when no redirect_en is present and occupancy < FIFO_DEPTH, so that every response has a reserved slot.
REQ-019 SHALL hold imem_addr = fetch_pc stable while imem_req is high and gnt is low.
REQ-020 On imem_req && imem_gnt: pending_pc <= fetch_pc, fetch_pc <= fetch_pc + 4 (mod 2^32, so 32'hFFFF_FFFC wraps to 0), and the FSM goes to WAIT.
REQ-021 In WAIT, on imem_rvalid: push {pending_pc, imem_rdata} into the FIFO and go to FETCH.
REQ-022 SHALL drive instr_valid = FIFO non-empty, with instruction/pc taken from the FIFO head (0-cycle read).
REQ-023 When the FIFO is empty: instruction = NOP 32'h0000_0013 and pc = 0.
REQ-024 SHALL pop the FIFO when instr_valid && !stall; a push and a pop in the same cycle leave occupancy unchanged.
REQ-025 Minimum latency: a gnt in the same cycle as the request plus rvalid on the next cycle gives instr_valid on the following cycle (2 cycles from request).
REQ-026 redirect_en has priority over stall, pop, push and gnt; at the edge it: empties the FIFO, sets fetch_pc <= {redirect_pc[31:2],2'b00}, and forces instr_valid to 0 next cycle.
REQ-027 Redirect in WAIT without rvalid, or in FETCH coinciding with gnt -> DRAIN.
REQ-028 Redirect in WAIT with rvalid in the same cycle -> the data is discarded and the FSM goes to FETCH.
REQ-029 In DRAIN: imem_req = 0; the next rvalid is discarded and the FSM goes to FETCH; a further redirect in DRAIN updates fetch_pc and stays in DRAIN.
REQ-030 An imem_rvalid in FETCH SHALL be ignored.
REQ-031 Once a request is accepted, fetching SHALL continue in PC order with no instruction dropped or duplicated absent a redirect.

Reset
REQ-032 While rst = 1 at a clock edge: state <= FETCH, fetch_pc <= RESET_PC, pending_pc <= 0, FIFO occupancy <= 0.
REQ-033 During reset, imem_req = 0 and instr_valid = 0.
REQ-034 The first request SHALL appear in the first cycle after rst deasserts, with imem_addr = RESET_PC.
REQ-035 Reset mid-WAIT or mid-DRAIN SHALL abandon the transaction; the instruction memory shares rst and issues no post-reset response.

Structure
REQ-036 Package if_pkg SHALL hold: the FSM state enum {FETCH, WAIT, DRAIN}, NOP_INSTR = 32'h0000_0013, and the default RESET_PC.
REQ-037 The buffer SHALL be one sub-module, fetch_fifo (parameterised depth, {pc, instr} 64-bit entries, push/pop/flush, count, head output).

Verification
REQ-038 Reset release, gnt tied 1, rvalid one cycle after gnt, stall = 0 -> pc sequence 0, 4, 8, 12 on consecutive valid cycles after the 2-cycle fill.
REQ-039 stall held high 6 cycles -> FIFO fills to FIFO_DEPTH; imem_req drops; instruction/pc frozen at pc = 0x0; on release the sequence resumes 0x0, 0x4, ... with none lost.
REQ-040 redirect_en with redirect_pc = 0x100 while in WAIT, stale rvalid 3 cycles later -> stale data never valid; next request addr = 0x100; first valid pc = 0x100.
REQ-041 Redirect on the same cycle as rvalid, target 0x203 -> data dropped; next imem_addr = 0x200.
REQ-042 RESET_PC = 0xFFFF_FFF8 -> valid pcs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-043 rst asserted during WAIT, then released -> instr_valid = 0 and imem_addr = RESET_PC on the first post-reset cycle.
